// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the program run sequencer.
package prog_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        HOLD,
        RUN,
        FINISH
    } state_t;

    localparam int NUM_PROG_DEF = 3;
    localparam int START_PC_W   = 10;

    // Entry points of the programs loaded in instruction memory.
    function automatic logic [START_PC_W-1:0] start_pc(input logic [1:0] idx);
        logic [START_PC_W-1:0] pc;
        case (idx)
            2'd0:    pc = 10'h000;
            2'd1:    pc = 10'h040;
            2'd2:    pc = 10'h080;
            default: pc = 10'h0C0;
        endcase
        return pc;
    endfunction

endpackage

// File: rtl/next_prog_pick.sv
// Priority picker: returns the lowest set bit of the pending-program mask.
module next_prog_pick
    import prog_seq_pkg::*;
#(
    parameter int NUM_PROG = NUM_PROG_DEF
) (
    input  logic [NUM_PROG-1:0] pending,
    output logic [1:0]          idx,
    output logic                valid
);

    // Scan from the top down so the lowest pending index is the last write.
    always_comb begin
        idx   = 2'd0;
        valid = 1'b0;
        for (int i = NUM_PROG - 1; i >= 0; i--) begin
            if (pending[i]) begin
                idx   = 2'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// Run controller for the single-cycle core: launches the selected programs
// one after another, holding the core in reset between them.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for go, core held in reset
// SELECT | choose next pending program, or finish if none is left
// HOLD   | core held in reset for RST_HOLD cycles with start PC shown
// RUN    | core released, waiting for done or timeout
// FINISH | one-cycle all_done pulse, busy drops on the way to IDLE
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int NUM_PROG = NUM_PROG_DEF,
    parameter int PC_W     = 10,
    parameter int RST_HOLD = 2,
    parameter int TO_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic [NUM_PROG-1:0] prog_mask,
    input  logic [TO_W-1:0]     timeout_limit,
    input  logic                core_done,
    output logic                core_reset,
    output logic [PC_W-1:0]     core_start_pc,
    output logic [1:0]          prog_id,
    output logic                busy,
    output logic [NUM_PROG-1:0] done_mask,
    output logic [NUM_PROG-1:0] timeout_err,
    output logic                all_done
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    state_t                state_q, state_d;
    logic [NUM_PROG-1:0]   mask_q, mask_d;
    logic [NUM_PROG-1:0]   visited_q, visited_d;
    logic [NUM_PROG-1:0]   done_mask_q, done_mask_d;
    logic [NUM_PROG-1:0]   timeout_err_q, timeout_err_d;
    logic [1:0]            prog_id_q, prog_id_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [TO_W-1:0]       run_cnt_q, run_cnt_d;
    logic                  core_reset_q, core_reset_d;
    logic                  busy_q, busy_d;
    logic                  all_done_q, all_done_d;

    logic [NUM_PROG-1:0]   pending;
    logic [1:0]            pick_idx;
    logic                  pick_valid;
    logic                  done_ok;
    logic                  timed_out;

    assign pending = mask_q & ~visited_q;

    next_prog_pick #(
        .NUM_PROG (NUM_PROG)
    ) u_pick (
        .pending (pending),
        .idx     (pick_idx),
        .valid   (pick_valid)
    );

    // A done seen in the first RUN cycle may be left over from the previous
    // program, so it only counts once the core has run at least one cycle.
    assign done_ok   = core_done && (run_cnt_q != '0);
    assign timed_out = (timeout_limit != '0) && (run_cnt_q == timeout_limit - TO_W'(1));

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        visited_d     = visited_q;
        done_mask_d   = done_mask_q;
        timeout_err_d = timeout_err_q;
        prog_id_d     = prog_id_q;
        pc_d          = pc_q;
        hold_cnt_d    = hold_cnt_q;
        run_cnt_d     = run_cnt_q;
        core_reset_d  = core_reset_q;
        busy_d        = busy_q;
        all_done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (go) begin
                    mask_d        = prog_mask;
                    visited_d     = '0;
                    done_mask_d   = '0;
                    timeout_err_d = '0;
                    busy_d        = 1'b1;
                    state_d       = SELECT;
                end
            end
            SELECT: begin
                if (pick_valid) begin
                    prog_id_d            = pick_idx;
                    pc_d                 = PC_W'(start_pc(pick_idx));
                    visited_d[pick_idx]  = 1'b1;
                    hold_cnt_d           = HOLD_W'(RST_HOLD - 1);
                    state_d              = HOLD;
                end else begin
                    all_done_d = 1'b1;
                    state_d    = FINISH;
                end
            end
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    core_reset_d = 1'b0;
                    run_cnt_d    = '0;
                    state_d      = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            RUN: begin
                if (done_ok) begin
                    done_mask_d[prog_id_q] = 1'b1;
                    core_reset_d           = 1'b1;
                    state_d                = SELECT;
                end else if (timed_out) begin
                    timeout_err_d[prog_id_q] = 1'b1;
                    core_reset_d             = 1'b1;
                    state_d                  = SELECT;
                end else if (run_cnt_q != '1) begin
                    run_cnt_d = run_cnt_q + TO_W'(1);
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                core_reset_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset aborts any run at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            mask_q        <= '0;
            visited_q     <= '0;
            done_mask_q   <= '0;
            timeout_err_q <= '0;
            prog_id_q     <= 2'd0;
            pc_q          <= PC_W'(start_pc(2'd0));
            hold_cnt_q    <= '0;
            run_cnt_q     <= '0;
            core_reset_q  <= 1'b1;
            busy_q        <= 1'b0;
            all_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            visited_q     <= visited_d;
            done_mask_q   <= done_mask_d;
            timeout_err_q <= timeout_err_d;
            prog_id_q     <= prog_id_d;
            pc_q          <= pc_d;
            hold_cnt_q    <= hold_cnt_d;
            run_cnt_q     <= run_cnt_d;
            core_reset_q  <= core_reset_d;
            busy_q        <= busy_d;
            all_done_q    <= all_done_d;
        end
    end

    assign core_reset    = core_reset_q;
    assign core_start_pc = pc_q;
    assign prog_id       = prog_id_q;
    assign busy          = busy_q;
    assign done_mask     = done_mask_q;
    assign timeout_err   = timeout_err_q;
    assign all_done      = all_done_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: a simple core model answers each release after a
// per-program delay; expected run order, window lengths and status bits come
// from a transaction-level model of the sequencing rules.
module tb_prog_sequencer;

    localparam int NP       = 3;
    localparam int PC_W     = 10;
    localparam int RST_HOLD = 2;
    localparam int TO_W     = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            go;
    logic [NP-1:0]   prog_mask;
    logic [TO_W-1:0] timeout_limit;
    logic            core_done;
    logic            core_reset;
    logic [PC_W-1:0] core_start_pc;
    logic [1:0]      prog_id;
    logic            busy;
    logic [NP-1:0]   done_mask;
    logic [NP-1:0]   timeout_err;
    logic            all_done;

    int n_total = 0;
    int n_bad   = 0;

    // core model: dly[i]=0 means program i never signals done
    int dly[NP];
    bit stale_lvl;
    int low_cnt;
    int last_id;

    prog_sequencer #(
        .NUM_PROG (NP),
        .PC_W     (PC_W),
        .RST_HOLD (RST_HOLD),
        .TO_W     (TO_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .go            (go),
        .prog_mask     (prog_mask),
        .timeout_limit (timeout_limit),
        .core_done     (core_done),
        .core_reset    (core_reset),
        .core_start_pc (core_start_pc),
        .prog_id       (prog_id),
        .busy          (busy),
        .done_mask     (done_mask),
        .timeout_err   (timeout_err),
        .all_done      (all_done)
    );

    always #5 clk = ~clk;

    // Core: done rises on the dly-th cycle out of reset and stays up; while in
    // reset it shows a possibly stale level.
    always @(negedge clk) begin
        if (core_reset) begin
            low_cnt   = 0;
            core_done = stale_lvl;
        end else begin
            low_cnt   = low_cnt + 1;
            core_done = (dly[prog_id] != 0) && (low_cnt >= dly[prog_id]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pc_of(input int i);
        return 32'(i * 'h40);
    endfunction

    // Cycles the core stays released: done is honoured from its second cycle,
    // timeout ends the run after lim cycles, a tie goes to done.
    function automatic int exp_len(input int d, input int lim, output bit by_done);
        int dn;
        dn = (d < 2) ? 2 : d;
        if (lim != 0 && (d == 0 || lim < dn)) begin
            by_done = 1'b0;
            return lim;
        end
        by_done = 1'b1;
        return dn;
    endfunction

    task automatic run_seq(input logic [2:0] m, input int lim, input int d0, input int d1,
                           input int d2, input bit stale, input bit go_pulse);
        int k;
        int len;
        int want;
        bit by_done;
        logic [2:0] exp_dm;
        logic [2:0] exp_te;
        dly[0] = d0;
        dly[1] = d1;
        dly[2] = d2;
        stale_lvl = stale;
        timeout_limit = TO_W'(lim);
        exp_dm = '0;
        exp_te = '0;
        @(negedge clk);
        go = 1'b1;
        prog_mask = m;
        @(negedge clk);
        go = 1'b0;
        prog_mask = 3'($urandom);
        chk("busy_after_go", busy, 1);
        k = 1;
        for (int i = 0; i < NP; i++) begin
            if (m[i]) begin
                while (core_reset && k < 64) begin
                    @(negedge clk);
                    k++;
                end
                chk("gap_to_release", k, RST_HOLD + 2);
                chk("prog_id", prog_id, i);
                chk("start_pc", core_start_pc, pc_of(i));
                want = exp_len(dly[i], lim, by_done);
                len = 0;
                while (!core_reset && len < 100) begin
                    len++;
                    go = (go_pulse && len == 1);
                    if (go) prog_mask = 3'b111;
                    @(negedge clk);
                end
                go = 1'b0;
                chk("run_len", len, want);
                if (by_done) exp_dm[i] = 1'b1;
                else         exp_te[i] = 1'b1;
                last_id = i;
                k = 1;
            end
        end
        while (!all_done && k < 64) begin
            @(negedge clk);
            k++;
        end
        chk("gap_to_all_done", k, 2);
        chk("done_mask", done_mask, exp_dm);
        chk("timeout_err", timeout_err, exp_te);
        @(negedge clk);
        chk("all_done_width", all_done, 0);
        chk("busy_end", busy, 0);
        chk("prog_id_hold", prog_id, last_id);
        chk("pc_hold", core_start_pc, pc_of(last_id));
        chk("core_reset_idle", core_reset, 1);
    endtask

    initial begin
        int k;
        logic [2:0] m;
        int lim;
        int d[NP];
        reset = 1'b1;
        go = 1'b0;
        prog_mask = '0;
        timeout_limit = '0;
        stale_lvl = 1'b0;
        last_id = 0;
        for (int i = 0; i < NP; i++) dly[i] = 1;
        repeat (3) @(negedge clk);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_all_done", all_done, 0);
        chk("rst_prog_id", prog_id, 0);
        chk("rst_pc", core_start_pc, pc_of(0));
        chk("rst_done_mask", done_mask, 0);
        chk("rst_timeout_err", timeout_err, 0);
        reset = 1'b0;

        run_seq(3'b111, 0, 10, 10, 10, 1'b0, 1'b0);
        run_seq(3'b111, 20, 10, 0, 10, 1'b0, 1'b0);
        run_seq(3'b000, 0, 5, 5, 5, 1'b0, 1'b0);
        run_seq(3'b100, 0, 1, 1, 1, 1'b1, 1'b0);
        run_seq(3'b111, 5, 5, 2, 30, 1'b0, 1'b1);
        run_seq(3'b011, 1, 1, 3, 3, 1'b1, 1'b1);

        // asynchronous reset in the middle of program 1
        dly[0] = 4;
        dly[1] = 40;
        dly[2] = 40;
        timeout_limit = '0;
        @(negedge clk);
        go = 1'b1;
        prog_mask = 3'b111;
        @(negedge clk);
        go = 1'b0;
        k = 0;
        while (!(prog_id == 2'd1 && !core_reset) && k < 64) begin
            @(negedge clk);
            k++;
        end
        chk("reach_prog1", (prog_id == 2'd1 && !core_reset), 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_core_reset", core_reset, 1);
        chk("arst_busy", busy, 0);
        chk("arst_prog_id", prog_id, 0);
        chk("arst_pc", core_start_pc, pc_of(0));
        chk("arst_done_mask", done_mask, 0);
        chk("arst_all_done", all_done, 0);
        @(negedge clk);
        reset = 1'b0;
        last_id = 0;
        run_seq(3'b111, 0, 3, 4, 5, 1'b1, 1'b0);

        for (int n = 0; n < 24; n++) begin
            m = 3'($urandom_range(0, 7));
            lim = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 25));
            for (int i = 0; i < NP; i++) begin
                d[i] = int'($urandom_range(0, 25));
                if (lim == 0 && d[i] == 0) d[i] = int'($urandom_range(1, 25));
            end
            run_seq(m, lim, d[0], d[1], d[2], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
